// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 inverse cipher with on-chip sequential key schedule
module aes_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_cipher,
  input  logic [127:0] in_key,
  input  logic         key_same,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_plain,
  output logic         busy
);

  localparam logic [3:0] LAST_RK = 4'(NR);

  // Forward S-box: byte x of the table sits at index x (MSB first).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same layout.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_WHITEN,
    S_ROUND,
    S_DONE
  } state_t;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; byte 0 of the column is bits [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] me [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] m9 [4];
    logic [7:0] a2, a4, a8;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      a2    = xt(a[i]);
      a4    = xt(a2);
      a8    = xt(a4);
      me[i] = a8 ^ a4 ^ a2;
      mb[i] = a8 ^ a2 ^ a[i];
      md[i] = a8 ^ a4 ^ a[i];
      m9[i] = a8 ^ a[i];
    end
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return res;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  plain_q, plain_d;
  logic          key_loaded_q, key_loaded_d;
  logic [127:0]  rk_q [0:10];

  logic          rk_we;
  logic [3:0]    rk_waddr;
  logic [127:0]  rk_wdata;

  logic [3:0]    prev_idx, rd_idx;
  logic [127:0]  rk_prev, rk_next, round_key;
  logic [31:0]   rot_w, sub_w, tmp_w;
  logic [31:0]   w0, w1, w2, w3;
  logic [127:0]  isr, isb_out, ark, imc;

  // Key schedule step: derive rk[cnt] from rk[cnt-1] with four forward S-boxes.
  always_comb begin
    prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    rk_prev  = rk_q[prev_idx];
    rot_w    = {rk_prev[23:0], rk_prev[31:24]};
    sub_w    = '0;
    for (int i = 0; i < 4; i++) begin
      sub_w[31-8*i -: 8] = SBOX[rot_w[31-8*i -: 8]];
    end
    tmp_w   = sub_w ^ {rcon(cnt_q), 24'h000000};
    w0      = rk_prev[127:96] ^ tmp_w;
    w1      = rk_prev[95:64]  ^ w0;
    w2      = rk_prev[63:32]  ^ w1;
    w3      = rk_prev[31:0]   ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  // Data round: InvShiftRows, sixteen inverse S-boxes, AddRoundKey(rk[cnt]), InvMixColumns.
  always_comb begin
    isr     = '0;
    isb_out = '0;
    imc     = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        isr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c-r)&3)) -: 8];
      end
    end
    for (int j = 0; j < 16; j++) begin
      isb_out[127-8*j -: 8] = INV_SBOX[isr[127-8*j -: 8]];
    end
    rd_idx    = (cnt_q > LAST_RK) ? LAST_RK : cnt_q;
    round_key = rk_q[rd_idx];
    ark       = isb_out ^ round_key;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    st_d         = st_q;
    plain_d      = plain_q;
    key_loaded_d = key_loaded_q;
    rk_we        = 1'b0;
    rk_waddr     = cnt_q;
    rk_wdata     = rk_next;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d = in_cipher;
          if (key_same && key_loaded_q) begin
            state_d = S_WHITEN;
          end else begin
            rk_we    = 1'b1;
            rk_waddr = 4'd0;
            rk_wdata = in_key;
            cnt_d    = 4'd1;
            state_d  = S_KEYEXP;
          end
        end
      end
      S_KEYEXP: begin
        rk_we    = 1'b1;
        rk_waddr = cnt_q;
        rk_wdata = rk_next;
        if (cnt_q == LAST_RK) begin
          key_loaded_d = 1'b1;
          state_d      = S_WHITEN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WHITEN: begin
        st_d    = st_q ^ rk_q[LAST_RK];
        cnt_d   = LAST_RK - 4'd1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q != 4'd0) begin
          st_d  = imc;
          cnt_d = cnt_q - 4'd1;
        end else begin
          plain_d = ark;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      st_q         <= '0;
      plain_q      <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      st_q         <= st_d;
      plain_q      <= plain_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  // Round-key buffer; contents survive reset, only key_loaded guards reuse.
  always_ff @(posedge clk) begin
    if (!rst && rk_we) begin
      rk_q[rk_waddr] <= rk_wdata;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_plain = plain_q;
  assign busy      = (state_q == S_KEYEXP) || (state_q == S_WHITEN) || (state_q == S_ROUND);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - randomized self-checking bench for aes_decrypt_iter against a byte-level AES model
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_cipher = '0;
  logic [127:0] in_key = '0;
  logic         key_same = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_plain;
  logic         busy;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cipher(in_cipher), .in_key(in_key), .key_same(key_same),
    .out_valid(out_valid), .out_ready(out_ready), .out_plain(out_plain), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkint(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gm(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [0:10][127:0] expand(input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] t [4];
    logic [7:0] rc, tmp;
    logic [0:10][127:0] rk;
    rc = 8'h01;
    for (int j = 0; j < 16; j++) w[j] = key[127-8*j -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp = t[0];
        t[0] = sb[t[1]] ^ rc; t[1] = sb[t[2]]; t[2] = sb[t[3]]; t[3] = sb[tmp];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) rk[r][127-8*j -: 8] = w[16*r+j];
    return rk;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c, input logic [127:0] k);
    logic [0:10][127:0] rk;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    rk = expand(k);
    for (int j = 0; j < 16; j++) s[j] = c[127-8*j -: 8] ^ rk[10][127-8*j -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) t[row+4*col] = s[row+4*((col-row+4)%4)];
      for (int j = 0; j < 16; j++) s[j] = isb[t[j]] ^ rk[r][127-8*j -: 8];
      if (r > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
          s[4*col+1] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
          s[4*col+2] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
          s[4*col+3] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
      end
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [0:10][127:0] rk;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    rk = expand(k);
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ rk[0][127-8*j -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) s[row+4*col] = t[row+4*((col+row)%4)];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gm(a0,8'h02) ^ gm(a1,8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gm(a1,8'h02) ^ gm(a2,8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gm(a2,8'h02) ^ gm(a3,8'h03);
          s[4*col+3] = gm(a0,8'h03) ^ a1 ^ a2 ^ gm(a3,8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[r][127-8*j -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // Transaction-level reference: idle / working for a fixed latency / holding the result.
  int           m_phase = 0;
  int           m_rem = 0;
  logic         m_kl = 1'b0;
  logic         m_started = 1'b0;
  logic [127:0] m_key = '0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_plain = '0;
  int           m_xfers = 0;
  int           dut_xfers = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase   <= 0;
      m_kl      <= 1'b0;
      m_plain   <= '0;
      m_started <= 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          if (key_same && m_kl) begin
            m_rem  <= 11;
            m_pend <= aes_dec(in_cipher, m_key);
          end else begin
            m_key  <= in_key;
            m_kl   <= 1'b1;
            m_rem  <= 21;
            m_pend <= aes_dec(in_cipher, in_key);
          end
          m_phase <= 1;
        end
        1: begin
          if (m_rem == 1) begin
            m_phase <= 2;
            m_plain <= m_pend;
          end
          m_rem <= m_rem - 1;
        end
        default: if (out_ready) begin
          m_phase <= 0;
          m_xfers <= m_xfers + 1;
        end
      endcase
      if (out_valid && out_ready) dut_xfers <= dut_xfers + 1;
    end
  end

  // Cycle-by-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (m_started) begin
      chk1("in_ready", in_ready, m_phase == 0);
      chk1("busy", busy, m_phase == 1);
      chk1("out_valid", out_valid, m_phase == 2);
      chk128("out_plain", out_plain, m_plain);
    end
  end

  task automatic send(input logic [127:0] c, input logic [127:0] k, input logic ks, input int hold,
                      output int lat, output logic [127:0] got);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk1("accept_timeout", in_ready, 1'b1);
    in_valid = 1'b1; in_cipher = c; in_key = k; key_same = ks; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_cipher = {4{$urandom}}; in_key = {4{$urandom}}; key_same = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 60) chk1("out_valid_timeout", out_valid, 1'b1);
    got = out_plain;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        in_valid = 1'($urandom); in_cipher = {4{$urandom}}; key_same = 1'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk1("in_ready_after_xfer", in_ready, 1'b1);
    chk1("out_valid_after_xfer", out_valid, 1'b0);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] D3 = 128'haaeabaaeabaaeabaaeabaaeabaaeabaa;
  localparam logic [127:0] K3 = 128'hf1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1;

  initial begin
    int lat, x0;
    logic [127:0] got, c, k, curk, expp;
    logic [127:0] kp [3];
    logic ks, kl, full;

    build_tables();
    chk128("model_enc_fips_b", aes_enc(P2, K2), C2);
    chk128("model_dec_fips_c1", aes_dec(C1, K1), P1);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(C1, K1, 1'b0, 0, lat, got);
    chkint("t1_latency", lat, 21);
    chk128("t1_plain", got, P1);

    send(C2, K2, 1'b0, 0, lat, got);
    chkint("t2_latency", lat, 21);
    chk128("t2_plain", got, P2);
    send(C2, {4{$urandom}}, 1'b1, 0, lat, got);
    chkint("t2_reuse_latency", lat, 11);
    chk128("t2_reuse_plain", got, P2);

    send(aes_enc(D3, K3), K3, 1'b0, 0, lat, got);
    chkint("t3_latency", lat, 21);
    chk128("t3_loopback", got, D3);

    send(C1, K1, 1'b0, 0, lat, got);
    x0 = dut_xfers;
    send(C1, {4{$urandom}}, 1'b1, 15, lat, got);
    chkint("t4_latency", lat, 11);
    chk128("t4_plain", got, P1);
    @(negedge clk);
    chkint("t4_one_transfer", dut_xfers - x0, 1);

    @(negedge clk);
    in_valid = 1'b1; in_cipher = C2; in_key = K2; key_same = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(C1, K1, 1'b1, 0, lat, got);
    chkint("t5_latency", lat, 21);
    chk128("t5_plain", got, P1);

    send(C2, K2, 1'b0, 0, lat, got);
    chkint("t6_latency", lat, 21);
    chk128("t6_plain", got, P2);

    kl = 1'b1;
    curk = K2;
    for (int i = 0; i < 3; i++) kp[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ks = 1'($urandom);
      k = kp[$urandom_range(0, 2)];
      c = {$urandom, $urandom, $urandom, $urandom};
      full = !(ks && kl);
      if (full) curk = k;
      expp = aes_dec(c, curk);
      send(c, k, ks, $urandom_range(0, 4), lat, got);
      kl = 1'b1;
      chkint("rand_latency", lat, full ? 21 : 11);
      chk128("rand_plain", got, expp);
    end

    repeat (2) @(negedge clk);
    chkint("transfer_count", dut_xfers, m_xfers);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
